// File: rtl/legv8_pkg.sv
// Shared LEGv8 front-end definitions: immediate-format codes, opcode fields
// and the fetch state encoding.
package legv8_pkg;

  localparam logic [2:0] IMM_B   = 3'b000;
  localparam logic [2:0] IMM_CB  = 3'b001;
  localparam logic [2:0] IMM_I   = 3'b010;
  localparam logic [2:0] IMM_D   = 3'b011;
  localparam logic [2:0] IMM_IW  = 3'b100;
  localparam logic [2:0] IMM_INV = 3'b111;

  localparam logic [5:0]  OP_B     = 6'b000101;
  localparam logic [7:0]  OP_CBZ   = 8'b10110100;
  localparam logic [7:0]  OP_CBNZ  = 8'b10110101;
  localparam logic [9:0]  OP_ADDI  = 10'b1001000100;
  localparam logic [9:0]  OP_ADDIS = 10'b1011000100;
  localparam logic [9:0]  OP_SUBI  = 10'b1101000100;
  localparam logic [9:0]  OP_SUBIS = 10'b1111000100;
  localparam logic [9:0]  OP_ANDI  = 10'b1001001000;
  localparam logic [9:0]  OP_ORRI  = 10'b1011001000;
  localparam logic [9:0]  OP_EORI  = 10'b1101001000;
  localparam logic [10:0] OP_LDUR  = 11'b11111000010;
  localparam logic [10:0] OP_STUR  = 11'b11111000000;
  localparam logic [8:0]  OP_MOVZ  = 9'b110100101;

  typedef enum logic [1:0] {
    ST_REQ   = 2'd0,
    ST_HOLD  = 2'd1,
    ST_FAULT = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/imm_ctrl_decode.sv
// Combinational immediate-format decode from the top 11 opcode bits.
// The MOVZ (IW) format is recognised only when IFETCH_MOVZ_EN is defined.
module imm_ctrl_decode
  import legv8_pkg::*;
(
  input  logic [10:0] opcode,
  output logic [2:0]  imm_ctrl
);

  // Ordered checks: the first matching format wins.
  always_comb begin
    imm_ctrl = IMM_INV;
    if (opcode[10:5] == OP_B) begin
      imm_ctrl = IMM_B;
    end else if (opcode[10:3] == OP_CBZ || opcode[10:3] == OP_CBNZ) begin
      imm_ctrl = IMM_CB;
    end else if (opcode[10:1] == OP_ADDI  || opcode[10:1] == OP_ADDIS ||
                 opcode[10:1] == OP_SUBI  || opcode[10:1] == OP_SUBIS ||
                 opcode[10:1] == OP_ANDI  || opcode[10:1] == OP_ORRI  ||
                 opcode[10:1] == OP_EORI) begin
      imm_ctrl = IMM_I;
    end else if (opcode == OP_LDUR || opcode == OP_STUR) begin
      imm_ctrl = IMM_D;
    end else if (opcode[10:2] == OP_MOVZ) begin
`ifdef IFETCH_MOVZ_EN
      imm_ctrl = IMM_IW;
`else
      imm_ctrl = IMM_INV;
`endif
    end
  end

endmodule

// File: rtl/ifetch_unit.sv
// LEGv8 instruction fetch: PC, req/ack memory port, held instruction for decode.
// Optional IFETCH_MOVZ_EN enables the IW immediate format in the decoder.
module ifetch_unit
  import legv8_pkg::*;
#(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter int          MAX_WAIT = 15
) (
  input  logic        CLK,
  input  logic        Reset,
  output logic        ImemReq,
  output logic [63:0] ImemAddr,
  input  logic        ImemAck,
  input  logic [31:0] ImemData,
  input  logic        Redirect,
  input  logic [63:0] RedirectPC,
  output logic        InstrValid,
  input  logic        InstrReady,
  output logic [31:0] Instr,
  output logic [25:0] Imm26,
  output logic [2:0]  ImmCtrl,
  output logic [63:0] InstrPC,
  output logic        Fault,
  output logic [1:0]  FetchState
);

  // Handshakes: ImemReq/ImemAck transfer a word in any cycle both are high;
  // InstrValid/InstrReady consume the held word in any cycle both are high.

  fetch_state_e state, state_next;
  logic [63:0]  pc, pc_next;
  logic [3:0]   wait_cnt, wait_cnt_next;
  logic         load_instr;
  logic [2:0]   imm_ctrl_dec;
  logic         unused_bits;

  assign unused_bits = ^RedirectPC[1:0];

  imm_ctrl_decode u_decode (
    .opcode   (ImemData[31:21]),
    .imm_ctrl (imm_ctrl_dec)
  );

  always_comb begin
    state_next    = state;
    pc_next       = pc;
    wait_cnt_next = wait_cnt;
    load_instr    = 1'b0;
    case (state)
      ST_REQ: begin
        if (Redirect) begin
          pc_next       = {RedirectPC[63:2], 2'b00};
          wait_cnt_next = 4'd0;
        end else if (ImemAck) begin
          load_instr    = 1'b1;
          pc_next       = pc + 64'd4;
          wait_cnt_next = 4'd0;
          state_next    = ST_HOLD;
        end else if (wait_cnt == 4'(MAX_WAIT - 1)) begin
          state_next = ST_FAULT;
        end else begin
          wait_cnt_next = wait_cnt + 4'd1;
        end
      end
      ST_HOLD: begin
        // A redirect here also retires the held word.
        if (Redirect) begin
          pc_next       = {RedirectPC[63:2], 2'b00};
          wait_cnt_next = 4'd0;
          state_next    = ST_REQ;
        end else if (InstrReady) begin
          wait_cnt_next = 4'd0;
          state_next    = ST_REQ;
        end
      end
      ST_FAULT: state_next = ST_FAULT;
      default:  state_next = ST_FAULT;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state    <= ST_REQ;
      pc       <= RESET_PC;
      wait_cnt <= 4'd0;
      Instr    <= 32'd0;
      ImmCtrl  <= IMM_INV;
      InstrPC  <= 64'd0;
    end else begin
      state    <= state_next;
      pc       <= pc_next;
      wait_cnt <= wait_cnt_next;
      if (load_instr) begin
        Instr   <= ImemData;
        ImmCtrl <= imm_ctrl_dec;
        InstrPC <= pc;
      end
    end
  end

  assign ImemReq    = (state == ST_REQ) && !Reset;
  assign ImemAddr   = pc;
  assign InstrValid = (state == ST_HOLD);
  assign Fault      = (state == ST_FAULT);
  assign Imm26      = Instr[25:0];
  assign FetchState = state;

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit: reset, fetch/hold, redirect, decode formats,
// PC wrap and fetch-timeout fault.
module tb_ifetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_data;
  logic        redirect;
  logic [63:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [25:0] imm26;
  logic [2:0]  imm_ctrl;
  logic [63:0] instr_pc;
  logic        fault;
  logic [1:0]  fetch_state;

  int n_checks = 0;
  int n_fails  = 0;

`ifdef IFETCH_MOVZ_EN
  localparam logic [2:0] MOVZ_EXP = 3'b100;
`else
  localparam logic [2:0] MOVZ_EXP = 3'b111;
`endif

  ifetch_unit #(.RESET_PC(64'h100), .MAX_WAIT(15)) dut (
    .CLK        (clk),
    .Reset      (reset),
    .ImemReq    (imem_req),
    .ImemAddr   (imem_addr),
    .ImemAck    (imem_ack),
    .ImemData   (imem_data),
    .Redirect   (redirect),
    .RedirectPC (redirect_pc),
    .InstrValid (instr_valid),
    .InstrReady (instr_ready),
    .Instr      (instr),
    .Imm26      (imm26),
    .ImmCtrl    (imm_ctrl),
    .InstrPC    (instr_pc),
    .Fault      (fault),
    .FetchState (fetch_state)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #20000;
    $display("FAIL watchdog: time limit reached, got 0 required 1 (%0d checks, %0d failures)",
             n_checks, n_fails);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h required 0x%0h", tag, got, exp);
    end
  endtask

  // One clock: inputs take effect at posedge, outputs sampled at negedge.
  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_in(input logic ack, input logic [31:0] data,
                        input logic rdy, input logic rd, input logic [63:0] rpc);
    imem_ack    = ack;
    imem_data   = data;
    instr_ready = rdy;
    redirect    = rd;
    redirect_pc = rpc;
  endtask

  initial begin
    reset = 1'b1;
    set_in(1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 64'h0);
    cyc();
    cyc();
    // Reset state; the ack held through reset must be ignored.
    check("rst_req",    {63'd0, imem_req},    64'd0);
    check("rst_addr",   imem_addr,            64'h100);
    check("rst_valid",  {63'd0, instr_valid}, 64'd0);
    check("rst_instr",  {32'd0, instr},       64'd0);
    check("rst_imm26",  {38'd0, imm26},       64'd0);
    check("rst_ctrl",   {61'd0, imm_ctrl},    64'h7);
    check("rst_ipc",    instr_pc,             64'd0);
    check("rst_fault",  {63'd0, fault},       64'd0);

    // Zero-wait fetch of a B instruction.
    reset = 1'b0;
    set_in(1'b0, 32'h0, 1'b0, 1'b0, 64'h0);
    #1;
    check("f1_req",  {63'd0, imem_req}, 64'd1);
    check("f1_addr", imem_addr,         64'h100);
    set_in(1'b1, 32'h14000003, 1'b0, 1'b0, 64'h0);
    cyc();
    check("f1_valid", {63'd0, instr_valid}, 64'd1);
    check("f1_instr", {32'd0, instr},       64'h14000003);
    check("f1_ctrl",  {61'd0, imm_ctrl},    64'h0);
    check("f1_imm26", {38'd0, imm26},       64'h3);
    check("f1_ipc",   instr_pc,             64'h100);
    check("f1_noreq", {63'd0, imem_req},    64'd0);
    set_in(1'b0, 32'h0, 1'b1, 1'b0, 64'h0);
    cyc();
    check("f2_req",   {63'd0, imem_req},    64'd1);
    check("f2_addr",  imem_addr,            64'h104);
    check("f2_valid", {63'd0, instr_valid}, 64'd0);

    // I-format word held for 5 cycles with decode stalled.
    set_in(1'b1, 32'h91000421, 1'b0, 1'b0, 64'h0);
    cyc();
    set_in(1'b0, 32'h0, 1'b0, 1'b0, 64'h0);
    for (int i = 0; i < 5; i++) begin
      check("hold_valid", {63'd0, instr_valid}, 64'd1);
      check("hold_instr", {32'd0, instr},       64'h91000421);
      check("hold_ctrl",  {61'd0, imm_ctrl},    64'h2);
      check("hold_ipc",   instr_pc,             64'h104);
      check("hold_noreq", {63'd0, imem_req},    64'd0);
      cyc();
    end
    instr_ready = 1'b1;
    cyc();
    instr_ready = 1'b0;
    check("h_req",  {63'd0, imem_req}, 64'd1);
    check("h_addr", imem_addr,         64'h108);

    // Redirect colliding with an ack: word dropped, target aligned.
    set_in(1'b1, 32'hD2800020, 1'b0, 1'b1, 64'h2003);
    cyc();
    check("rd_valid", {63'd0, instr_valid}, 64'd0);
    check("rd_req",   {63'd0, imem_req},    64'd1);
    check("rd_addr",  imem_addr,            64'h2000);
    check("rd_instr", {32'd0, instr},       64'h91000421);

    // MOVZ decode depends on the build option.
    set_in(1'b1, 32'hD2800020, 1'b0, 1'b0, 64'h0);
    cyc();
    check("mz_ctrl", {61'd0, imm_ctrl}, {61'd0, MOVZ_EXP});
    check("mz_ipc",  instr_pc,          64'h2000);

    // Redirect to the last word, then wrap with a D-format word.
    set_in(1'b0, 32'h0, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC);
    cyc();
    check("w_addr", imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    set_in(1'b1, 32'hF8400000, 1'b0, 1'b0, 64'h0);
    cyc();
    check("w_ctrl", {61'd0, imm_ctrl}, 64'h3);
    check("w_ipc",  instr_pc,          64'hFFFF_FFFF_FFFF_FFFC);
    check("w_addr0", imem_addr,        64'h0);
    set_in(1'b0, 32'h0, 1'b1, 1'b0, 64'h0);
    cyc();
    set_in(1'b1, 32'hB4000040, 1'b0, 1'b0, 64'h0);
    cyc();
    check("cb_ctrl", {61'd0, imm_ctrl}, 64'h1);
    check("cb_ipc",  instr_pc,          64'h0);

    // Redirect together with InstrReady in HOLD: redirect target wins.
    set_in(1'b0, 32'h0, 1'b1, 1'b1, 64'h40);
    cyc();
    check("rh_addr",  imem_addr,            64'h40);
    check("rh_valid", {63'd0, instr_valid}, 64'd0);
    check("rh_req",   {63'd0, imem_req},    64'd1);

    // No ack: 15 waiting cycles, then Fault.
    set_in(1'b0, 32'h0, 1'b0, 1'b0, 64'h0);
    for (int i = 0; i < 14; i++) cyc();
    check("to_nofault", {63'd0, fault},    64'd0);
    check("to_req14",   {63'd0, imem_req}, 64'd1);
    cyc();
    check("to_fault", {63'd0, fault},    64'd1);
    check("to_noreq", {63'd0, imem_req}, 64'd0);
    set_in(1'b1, 32'h14000003, 1'b1, 1'b1, 64'h3000);
    cyc();
    check("ft_fault", {63'd0, fault},       64'd1);
    check("ft_addr",  imem_addr,            64'h40);
    check("ft_noreq", {63'd0, imem_req},    64'd0);
    check("ft_valid", {63'd0, instr_valid}, 64'd0);

    // Reset leaves FAULT and restores the PC.
    set_in(1'b0, 32'h0, 1'b0, 1'b0, 64'h0);
    reset = 1'b1;
    cyc();
    check("rr_fault", {63'd0, fault},    64'd0);
    check("rr_addr",  imem_addr,         64'h100);
    check("rr_ctrl",  {61'd0, imm_ctrl}, 64'h7);
    reset = 1'b0;
    #1;
    check("rr_req", {63'd0, imem_req}, 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
